ctrl_pipe: RTL and testbench

Parametrised control-bundle pipeline that carries decoded control signals from the decode stage through STAGES downstream pipeline stages (default: execute, memory, writeback). It replaces fixed per-stage control registers with one configurable chain that adds:
- per-stage valid bits;
- stall propagation with automatic bubble insertion;
- flush that has priority over stall;
- saturating retire and bubble performance counters.

It sits between the main/ALU decoders and the datapath, next to the hazard unit.

---
 rtl/ctrl_pipe.sv | 124 ++++++++++++
 tb/tb_ctrl_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: configurable decode-to-writeback control-bundle pipeline.
// Each stage carries a valid bit and a control bundle. Stalls freeze the
// stalled stage and everything upstream of it, and insert bubbles below it.
// Flush clears a stage and wins over stall. Two saturating counters track
// what leaves the last stage.
module ctrl_pipe #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_ctrl,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    input  logic                      cnt_clr,
    output logic [STAGES-1:0]         out_valid,
    output logic [STAGES*WIDTH-1:0]   out_ctrl,
    output logic                      stall_up,
    output logic [CNT_W-1:0]          retired_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam int unsigned LAST = STAGES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0]       valid_q, valid_d;
    logic [STAGES*WIDTH-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]        retired_q, retired_d;
    logic [CNT_W-1:0]        bubble_q, bubble_d;

    logic [STAGES-1:0]       hold;
    logic                    last_adv;
    logic                    last_retire;
    logic                    last_bubble;

    // Hold of stage i is the OR of every stall request at or below it.
    always_comb begin
        hold       = '0;
        hold[LAST] = stall[LAST];
        for (int i = int'(LAST) - 1; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    // Decode and fetch must hold whenever any stage is stalled.
    assign stall_up = |stall;

    // Per-stage next state: flush, then hold, then bubble or advance.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;

        // Stage 0 loads from decode; an empty slot carries a zero bundle.
        if (flush[0]) begin
            valid_d[0]          = 1'b0;
            ctrl_d[0 +: WIDTH]  = '0;
        end else if (!hold[0]) begin
            valid_d[0]          = in_valid;
            ctrl_d[0 +: WIDTH]  = in_valid ? in_ctrl : '0;
        end

        for (int i = 1; i < int'(STAGES); i++) begin
            if (flush[i]) begin
                valid_d[i]              = 1'b0;
                ctrl_d[i*WIDTH +: WIDTH] = '0;
            end else if (!hold[i]) begin
                if (hold[i-1]) begin
                    valid_d[i]               = 1'b0;
                    ctrl_d[i*WIDTH +: WIDTH] = '0;
                end else begin
                    valid_d[i]               = valid_q[i-1];
                    ctrl_d[i*WIDTH +: WIDTH] = ctrl_q[(i-1)*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Classify the slot leaving the last stage this cycle.
    always_comb begin
        last_adv    = !stall[LAST] && !flush[LAST];
        last_retire = last_adv && valid_q[LAST];
        last_bubble = last_adv && !valid_q[LAST];
    end

    // Saturating counters; clear wins over a simultaneous increment.
    always_comb begin
        retired_d = retired_q;
        bubble_d  = bubble_q;
        if (cnt_clr) begin
            retired_d = '0;
            bubble_d  = '0;
        end else begin
            if (last_retire && (retired_q != CNT_MAX)) begin
                retired_d = retired_q + CNT_W'(1);
            end
            if (last_bubble && (bubble_q != CNT_MAX)) begin
                bubble_d = bubble_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            ctrl_q    <= '0;
            retired_q <= '0;
            bubble_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            retired_q <= retired_d;
            bubble_q  <= bubble_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_ctrl    = ctrl_q;
    assign retired_cnt = retired_q;
    assign bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: directed scenarios plus randomized traffic,
// checked against a slot-level behavioural model of the pipeline.
module tb_ctrl_pipe;

    localparam int unsigned ST = 3;
    localparam int unsigned W  = 14;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [W-1:0]    in_ctrl;
    logic [ST-1:0]   stall;
    logic [ST-1:0]   flush;
    logic            cnt_clr;

    logic [ST-1:0]   out_valid_a, out_valid_b;
    logic [ST*W-1:0] out_ctrl_a, out_ctrl_b;
    logic            stall_up_a, stall_up_b;
    logic [31:0]     retired_a, bubble_a;
    logic [3:0]      retired_b, bubble_b;

    ctrl_pipe #(.STAGES(ST), .WIDTH(W), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(out_valid_a), .out_ctrl(out_ctrl_a), .stall_up(stall_up_a),
        .retired_cnt(retired_a), .bubble_cnt(bubble_a)
    );

    ctrl_pipe #(.STAGES(ST), .WIDTH(W), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(out_valid_b), .out_ctrl(out_ctrl_b), .stall_up(stall_up_b),
        .retired_cnt(retired_b), .bubble_cnt(bubble_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one slot per stage, plus counters for both widths.
    bit          m_v [ST];
    logic [W-1:0] m_c [ST];
    longint      m_ret, m_bub, m_ret4, m_bub4;

    function automatic logic [ST*W-1:0] exp_ctrl();
        logic [ST*W-1:0] r;
        for (int i = 0; i < int'(ST); i++) r[i*W +: W] = m_c[i];
        return r;
    endfunction

    function automatic logic [ST-1:0] exp_valid();
        logic [ST-1:0] r;
        for (int i = 0; i < int'(ST); i++) r[i] = m_v[i];
        return r;
    endfunction

    // Advance one clock edge and apply the pipeline rules to the model.
    task automatic tick();
        bit           h [ST];
        bit           nv [ST];
        logic [W-1:0] nc [ST];
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < int'(ST); i++) begin m_v[i] = 0; m_c[i] = '0; end
            m_ret = 0; m_bub = 0; m_ret4 = 0; m_bub4 = 0;
        end else begin
            for (int i = 0; i < int'(ST); i++) h[i] = ((stall >> i) != 0);
            if (!stall[ST-1] && !flush[ST-1]) begin
                if (m_v[ST-1]) begin
                    if (m_ret  < 64'hFFFF_FFFF) m_ret++;
                    if (m_ret4 < 15) m_ret4++;
                end else begin
                    if (m_bub  < 64'hFFFF_FFFF) m_bub++;
                    if (m_bub4 < 15) m_bub4++;
                end
            end
            if (cnt_clr) begin m_ret = 0; m_bub = 0; m_ret4 = 0; m_bub4 = 0; end
            for (int i = 0; i < int'(ST); i++) begin nv[i] = m_v[i]; nc[i] = m_c[i]; end
            if (flush[0]) begin nv[0] = 0; nc[0] = '0; end
            else if (!h[0]) begin nv[0] = in_valid; nc[0] = in_valid ? in_ctrl : '0; end
            for (int i = 1; i < int'(ST); i++) begin
                if (flush[i]) begin nv[i] = 0; nc[i] = '0; end
                else if (!h[i]) begin
                    if (h[i-1]) begin nv[i] = 0; nc[i] = '0; end
                    else begin nv[i] = m_v[i-1]; nc[i] = m_c[i-1]; end
                end
            end
            for (int i = 0; i < int'(ST); i++) begin m_v[i] = nv[i]; m_c[i] = nc[i]; end
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_ctrl = '0; stall = '0; flush = '0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); stall = 3'b101;
        #1;
        checks++;
        if (stall_up_a !== 1'b1) begin errors++; $display("FAIL reset_stall_up got %b want 1", stall_up_a); end
        tick(); tick();
        stall = '0;
        #1;
        checks++;
        if (stall_up_a !== 1'b0) begin errors++; $display("FAIL reset_stall_up_low got %b want 0", stall_up_a); end
        checks++;
        if (out_valid_a !== 3'b000) begin errors++; $display("FAIL reset_valid got %b want 000", out_valid_a); end
        checks++;
        if (out_ctrl_a !== '0) begin errors++; $display("FAIL reset_ctrl got %h want 0", out_ctrl_a); end
        checks++;
        if (retired_a !== 32'd0 || bubble_a !== 32'd0 || retired_b !== 4'd0 || bubble_b !== 4'd0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d/%0d/%0d want 0", retired_a, bubble_a, retired_b, bubble_b);
        end
    endtask

    task automatic test_streaming();
        rst = 0;
        in_valid = 1;
        for (int k = 1; k <= 3; k++) begin
            in_ctrl = W'(k);
            tick();
            checks++;
            if (out_ctrl_a[0 +: W] !== W'(k) || out_valid_a[0] !== 1'b1) begin
                errors++; $display("FAIL stream_stage0 got %h/%b want %h/1", out_ctrl_a[0 +: W], out_valid_a[0], W'(k));
            end
        end
        checks++;
        if (out_ctrl_a[2*W +: W] !== 14'h0001 || out_valid_a[2] !== 1'b1) begin
            errors++; $display("FAIL stream_stage2 got %h/%b want 0001/1", out_ctrl_a[2*W +: W], out_valid_a[2]);
        end
        in_valid = 0; in_ctrl = '0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (retired_a !== 32'd3) begin errors++; $display("FAIL stream_retired got %0d want 3", retired_a); end
        checks++;
        if (bubble_a !== 32'd3) begin errors++; $display("FAIL stream_bubble got %0d want 3", bubble_a); end
        checks++;
        if (out_valid_a !== 3'b000) begin errors++; $display("FAIL stream_drained got %b want 000", out_valid_a); end
    endtask

    task automatic test_stall();
        in_valid = 1; in_ctrl = 14'h0B0; tick();
        in_ctrl = 14'h0A0; tick();
        in_ctrl = 14'h0C0; stall = 3'b010;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (stall_up_a !== 1'b1) begin errors++; $display("FAIL stall_up got %b want 1", stall_up_a); end
            tick();
            checks++;
            if (out_ctrl_a[0 +: W] !== 14'h0A0 || out_ctrl_a[W +: W] !== 14'h0B0 || out_valid_a[1:0] !== 2'b11) begin
                errors++; $display("FAIL stall_hold got %h/%h/%b want 0a0/0b0/11", out_ctrl_a[0 +: W], out_ctrl_a[W +: W], out_valid_a[1:0]);
            end
            checks++;
            if (out_valid_a[2] !== 1'b0 || out_ctrl_a[2*W +: W] !== '0) begin
                errors++; $display("FAIL stall_bubble got %b/%h want 0/0000", out_valid_a[2], out_ctrl_a[2*W +: W]);
            end
        end
        stall = '0;
        tick();
        checks++;
        if (out_ctrl_a !== {14'h0B0, 14'h0A0, 14'h0C0} || out_valid_a !== 3'b111) begin
            errors++; $display("FAIL stall_resume got %h/%b want %h/111", out_ctrl_a, out_valid_a, {14'h0B0, 14'h0A0, 14'h0C0});
        end
        in_valid = 0; in_ctrl = '0;
    endtask

    task automatic test_flush_priority();
        in_valid = 1; in_ctrl = 14'h3FFF; tick();
        in_valid = 0; in_ctrl = '0; stall = 3'b001; flush = 3'b001;
        #1;
        checks++;
        if (stall_up_a !== 1'b1) begin errors++; $display("FAIL flushprio_stall_up got %b want 1", stall_up_a); end
        tick();
        checks++;
        if (out_valid_a[0] !== 1'b0 || out_ctrl_a[0 +: W] !== '0) begin
            errors++; $display("FAIL flushprio_stage0 got %b/%h want 0/0000", out_valid_a[0], out_ctrl_a[0 +: W]);
        end
        checks++;
        if (out_ctrl_a !== exp_ctrl() || out_valid_a !== exp_valid()) begin
            errors++; $display("FAIL flushprio_pipe got %h/%b want %h/%b", out_ctrl_a, out_valid_a, exp_ctrl(), exp_valid());
        end
        stall = '0; flush = '0;
    endtask

    task automatic test_flush_advance();
        in_valid = 1; in_ctrl = 14'h0123; tick();
        in_valid = 0; in_ctrl = '0; flush = 3'b010; tick();
        checks++;
        if (out_valid_a[1] !== 1'b0 || out_ctrl_a[W +: W] !== '0) begin
            errors++; $display("FAIL flushadv_stage1 got %b/%h want 0/0000", out_valid_a[1], out_ctrl_a[W +: W]);
        end
        flush = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_ctrl_a[2*W +: W] == 14'h0123) begin
                errors++; $display("FAIL flushadv_leak got %h want not 0123", out_ctrl_a[2*W +: W]);
            end
        end
        checks++;
        if (retired_a !== 32'(m_ret)) begin errors++; $display("FAIL flushadv_retired got %0d want %0d", retired_a, m_ret); end
    endtask

    task automatic test_counters();
        cnt_clr = 1; tick(); cnt_clr = 0;
        checks++;
        if (retired_b !== 4'd0 || retired_a !== 32'd0) begin
            errors++; $display("FAIL cnt_clear got %0d/%0d want 0", retired_a, retired_b);
        end
        in_valid = 1;
        for (int k = 0; k < 20; k++) begin in_ctrl = W'($urandom); tick(); end
        in_valid = 0; in_ctrl = '0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (retired_b !== 4'd15) begin errors++; $display("FAIL cnt_saturate got %0d want 15", retired_b); end
        checks++;
        if (retired_a !== 32'd20) begin errors++; $display("FAIL cnt_wide got %0d want 20", retired_a); end
        in_valid = 1; in_ctrl = 14'h0055;
        for (int k = 0; k < 3; k++) tick();
        cnt_clr = 1; tick(); cnt_clr = 0;
        checks++;
        if (retired_a !== 32'd0 || retired_b !== 4'd0 || bubble_a !== 32'd0) begin
            errors++; $display("FAIL cnt_clr_retire got %0d/%0d/%0d want 0", retired_a, retired_b, bubble_a);
        end
        tick();
        checks++;
        if (retired_a !== 32'd1) begin errors++; $display("FAIL cnt_after_clr got %0d want 1", retired_a); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1; in_ctrl = 14'h1ABC;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (out_valid_a !== 3'b111) begin errors++; $display("FAIL rstmid_full got %b want 111", out_valid_a); end
        stall = 3'b100; flush = 3'b010; rst = 1; tick();
        checks++;
        if (out_valid_a !== 3'b000 || out_ctrl_a !== '0) begin
            errors++; $display("FAIL rstmid_pipe got %b/%h want 000/0", out_valid_a, out_ctrl_a);
        end
        checks++;
        if (retired_a !== 32'd0 || bubble_a !== 32'd0) begin
            errors++; $display("FAIL rstmid_counters got %0d/%0d want 0/0", retired_a, bubble_a);
        end
        rst = 0; idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 79) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_ctrl  = W'($urandom);
            for (int i = 0; i < int'(ST); i++) begin
                stall[i] = ($urandom_range(0, 4) == 0);
                flush[i] = ($urandom_range(0, 9) == 0);
            end
            cnt_clr  = ($urandom_range(0, 49) == 0);
            #1;
            checks++;
            if (stall_up_a !== (stall != 0) || stall_up_b !== (stall != 0)) begin
                errors++; $display("FAIL rand_stall_up cyc %0d got %b want %b", n, stall_up_a, stall != 0);
            end
            tick();
            checks++;
            if (out_valid_a !== exp_valid() || out_ctrl_a !== exp_ctrl()) begin
                errors++; $display("FAIL rand_pipe cyc %0d got %b/%h want %b/%h", n, out_valid_a, out_ctrl_a, exp_valid(), exp_ctrl());
            end
            checks++;
            if (out_valid_b !== exp_valid() || out_ctrl_b !== exp_ctrl()) begin
                errors++; $display("FAIL rand_pipe_b cyc %0d got %b/%h want %b/%h", n, out_valid_b, out_ctrl_b, exp_valid(), exp_ctrl());
            end
            checks++;
            if (retired_a !== 32'(m_ret) || bubble_a !== 32'(m_bub)) begin
                errors++; $display("FAIL rand_cnt cyc %0d got %0d/%0d want %0d/%0d", n, retired_a, bubble_a, m_ret, m_bub);
            end
            checks++;
            if (retired_b !== 4'(m_ret4) || bubble_b !== 4'(m_bub4)) begin
                errors++; $display("FAIL rand_cnt4 cyc %0d got %0d/%0d want %0d/%0d", n, retired_b, bubble_b, m_ret4, m_bub4);
            end
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < int'(ST); i++) begin m_v[i] = 0; m_c[i] = '0; end
        m_ret = 0; m_bub = 0; m_ret4 = 0; m_bub4 = 0;
        test_reset();
        test_streaming();
        test_stall();
        test_flush_priority();
        test_flush_advance();
        test_counters();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
